adder_pipe: RTL

Parametrised, pipelined successor to the single-cycle adder: a WIDTH-bit adder/subtractor split into SEG-bit carry segments, one segment per pipeline stage, with valid/ready handshakes on both sides. It adds subtraction and unsigned/signed saturation modes. It sits between an operand producer and a result consumer that may apply backpressure. One operation can be accepted per cycle, and results return in order.

---
 rtl/adder_pipe.sv | 123 ++++++++++++
 1 files changed

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG-bit carry segment per stage,
// valid/ready handshake on both sides, optional unsigned/signed saturation.
module adder_pipe #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int STAGES = WIDTH / SEG;
  localparam int MSB    = WIDTH - 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_USAT = 2'b10;
  localparam logic [1:0] OP_SSAT = 2'b11;

  // Element k holds the operands presented to segment stage k.
  logic [WIDTH-1:0] a_p    [STAGES];
  logic [WIDTH-1:0] bp_p   [STAGES];
  logic [WIDTH-1:0] sum_p  [STAGES];
  logic             c_p    [STAGES];
  logic [1:0]       op_p   [STAGES];
  logic             vld_p  [STAGES];
  logic [SEG:0]     seg_p  [STAGES];
  logic [WIDTH-1:0] nsum_p [STAGES];

  logic             en;
  logic [WIDTH-1:0] raw;
  logic             raw_cy;
  logic             raw_ov;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  function automatic logic [WIDTH-1:0] saturate(input logic [1:0]       mode,
                                                input logic [WIDTH-1:0] r,
                                                input logic             cy,
                                                input logic             ov,
                                                input logic             a_msb);
    logic [WIDTH-1:0] res;
    res = r;
    if (mode == OP_USAT && cy)
      res = {WIDTH{1'b1}};
    else if (mode == OP_SSAT && ov)
      res = a_msb ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    return res;
  endfunction

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_p[k]  = seg_add(a_p[k][k*SEG +: SEG], bp_p[k][k*SEG +: SEG], c_p[k]);
      nsum_p[k] = sum_p[k];
      nsum_p[k][k*SEG +: SEG] = seg_p[k][SEG-1:0];
    end
  end

  assign raw    = nsum_p[STAGES-1];
  assign raw_cy = seg_p[STAGES-1][SEG];
  assign raw_ov = (a_p[STAGES-1][MSB] == bp_p[STAGES-1][MSB]) &&
                  (raw[MSB] != a_p[STAGES-1][MSB]);

  // Operand capture (stage 0 input) and inter-segment registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
    end else if (en) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      a_p[0]   <= a;
      bp_p[0]  <= (op == OP_SUB) ? ~b : b;
      c_p[0]   <= (op == OP_SUB) ? 1'b1 : ((op == OP_ADD) ? cin : 1'b0);
      op_p[0]  <= op;
      sum_p[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        a_p[k]   <= a_p[k-1];
        bp_p[k]  <= bp_p[k-1];
        c_p[k]   <= seg_p[k-1][SEG];
        op_p[k]  <= op_p[k-1];
        sum_p[k] <= nsum_p[k-1];
      end
    end
  end

  // Last segment result, saturated and registered as the output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else if (en) begin
      out_valid <= vld_p[STAGES-1];
      sum       <= saturate(op_p[STAGES-1], raw, raw_cy, raw_ov, a_p[STAGES-1][MSB]);
      carry     <= raw_cy;
      overflow  <= raw_ov;
    end
  end

endmodule
